// File: rtl/uart_txd.sv
// UART transmitter: 8 data bits LSB first, optional odd/even parity, 1 or 2 stop bits.
// Bit timing is derived from clk by a baud counter wrapping every CLK_FREQ/BAUD clocks.
module uart_txd #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       I_tx_valid,
  input  logic [7:0] I_tx_data,
  output logic       O_tx_ready,
  output logic       O_tx_busy,
  output logic       O_tx_done,
  output logic       O_rs232_txd,
  output logic [2:0] O_dbg_state
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int CW      = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CNT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  generate
    if (BIT_CNT < 4) begin : g_bad_baud
      $error("uart_txd: CLK_FREQ/BAUD must be at least 4");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_txd: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_txd: STOP_BITS must be 1 or 2");
    end
  endgenerate

  // Handshake: a byte transfers on the rising edge where I_tx_valid && O_tx_ready;
  // valid while not ready is dropped, and data is only sampled on that edge.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_parity, w_parity_nxt;
  logic          r_txd, w_txd_nxt;
  logic          r_done, w_done_nxt;
  logic          w_wrap;

  assign w_wrap = (r_baud == BAUD_LAST);

  // The line flop is loaded with the level of the bit being entered, so the
  // first bit of each state appears on the line without a cycle of lag.
  always_comb begin
    w_state_nxt  = r_state;
    w_baud_nxt   = w_wrap ? '0 : r_baud + 1'b1;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_txd_nxt    = r_txd;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        w_txd_nxt  = 1'b1;
        if (I_tx_valid) begin
          w_state_nxt  = S_START;
          w_shift_nxt  = I_tx_data;
          w_parity_nxt = (PARITY == 1) ? ~^I_tx_data : ^I_tx_data;
          w_bit_nxt    = 3'd0;
          w_txd_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_wrap) begin
          w_state_nxt = S_DATA;
          w_txd_nxt   = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_wrap) begin
          if (r_bit == 3'd7) begin
            w_bit_nxt = 3'd0;
            if (PARITY != 0) begin
              w_state_nxt = S_PARITY;
              w_txd_nxt   = r_parity;
            end else begin
              w_state_nxt = S_STOP;
              w_txd_nxt   = 1'b1;
            end
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_txd_nxt   = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_wrap) begin
          w_state_nxt = S_STOP;
          w_bit_nxt   = 3'd0;
          w_txd_nxt   = 1'b1;
        end
      end
      S_STOP: begin
        if (w_wrap) begin
          if (r_bit == STOP_LAST) begin
            w_state_nxt = S_IDLE;
            w_bit_nxt   = 3'd0;
            w_done_nxt  = 1'b1;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
          w_txd_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= 3'd0;
      r_shift  <= 8'd0;
      r_parity <= 1'b0;
      r_txd    <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_baud   <= w_baud_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_parity <= w_parity_nxt;
      r_txd    <= w_txd_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign O_tx_ready  = (r_state == S_IDLE);
  assign O_tx_busy   = (r_state != S_IDLE);
  assign O_tx_done   = r_done;
  assign O_rs232_txd = r_txd;
  assign O_dbg_state = r_state;

endmodule

// File: tb/tb_uart_txd.sv
// Bench for uart_txd: four instances cover no parity, even, odd and two stop bits;
// the line is compared cycle by cycle against a frame built from the byte.
module tb_uart_txd;

  localparam int BC = 10;
  localparam int PAR_M  [4] = '{0, 2, 1, 0};
  localparam int STOP_M [4] = '{1, 1, 1, 2};

  logic       clk;
  logic       rst_n;
  logic       tx_valid [4];
  logic [7:0] tx_data  [4];
  logic       tx_ready [4];
  logic       tx_busy  [4];
  logic       tx_done  [4];
  logic       txd      [4];
  logic [2:0] dbg      [4];

  int n_cmp;
  int n_fail;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_txd #(
      .CLK_FREQ (50000000),
      .BAUD     (5000000),
      .PARITY   (PAR_M[g]),
      .STOP_BITS(STOP_M[g])
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .I_tx_valid (tx_valid[g]),
      .I_tx_data  (tx_data[g]),
      .O_tx_ready (tx_ready[g]),
      .O_tx_busy  (tx_busy[g]),
      .O_tx_done  (tx_done[g]),
      .O_rs232_txd(txd[g]),
      .O_dbg_state(dbg[g])
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  // offer a byte and wait (bounded) until it is accepted; returns in cycle 1 of the frame
  task automatic offer(input int k, input logic [7:0] d);
    int cnt;
    cnt = 0;
    tx_valid[k] = 1'b1;
    tx_data[k]  = d;
    while (tx_ready[k] !== 1'b1 && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    n_cmp++;
    if (cnt >= 500) begin
      n_fail++;
      $display("FAIL offer_timeout dut%0d ready=%b required 1", k, tx_ready[k]);
    end
    @(negedge clk);
  endtask

  // reference frame checker; ends at the negedge of the done cycle
  task automatic watch_frame(input int k, input logic [7:0] d, input bit hold,
                             input logic [7:0] d_next, input int pulse_at, input int abort_at);
    logic       exp_bits[$];
    logic [7:0] rx;
    logic [3:0] obs, exp;
    int         total, idx;
    exp_bits.push_back(1'b0);
    for (int j = 0; j < 8; j++) exp_bits.push_back(d[j]);
    if (PAR_M[k] == 1) exp_bits.push_back(($countones(d) % 2) == 0);
    if (PAR_M[k] == 2) exp_bits.push_back(($countones(d) % 2) == 1);
    for (int s = 0; s < STOP_M[k]; s++) exp_bits.push_back(1'b1);
    total = exp_bits.size() * BC;
    if (hold) tx_data[k] = d_next;
    else tx_valid[k] = 1'b0;
    rx = 8'h00;
    for (int i = 0; i < total; i++) begin
      if (i == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        obs = {txd[k], tx_ready[k], tx_busy[k], tx_done[k]};
        n_cmp++;
        if (obs !== 4'b1100) begin
          n_fail++;
          $display("FAIL async_reset dut%0d {txd,rdy,busy,done}=%b required 1100", k, obs);
        end
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          obs = {txd[k], tx_ready[k], tx_busy[k], tx_done[k]};
          n_cmp++;
          if (obs !== 4'b1100) begin
            n_fail++;
            $display("FAIL in_reset dut%0d {txd,rdy,busy,done}=%b required 1100", k, obs);
          end
        end
        rst_n = 1'b1;
        return;
      end
      if (pulse_at >= 0 && i == pulse_at) begin
        tx_valid[k] = 1'b1;
        tx_data[k]  = 8'h12;
      end else if (pulse_at >= 0 && i == pulse_at + 1) begin
        tx_valid[k] = 1'b0;
      end
      obs = {txd[k], tx_ready[k], tx_busy[k], tx_done[k]};
      exp = {exp_bits[i / BC], 3'b010};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL frame_cycle dut%0d byte=%h cycle=%0d {txd,rdy,busy,done}=%b required %b",
                 k, d, i, obs, exp);
      end
      idx = i / BC;
      if (i % BC == BC / 2 && idx >= 1 && idx <= 8) rx[idx-1] = txd[k];
      @(negedge clk);
    end
    obs = {txd[k], tx_ready[k], tx_busy[k], tx_done[k]};
    n_cmp++;
    if (obs !== 4'b1101) begin
      n_fail++;
      $display("FAIL done_cycle dut%0d byte=%h {txd,rdy,busy,done}=%b required 1101", k, d, obs);
    end
    n_cmp++;
    if (rx !== d) begin
      n_fail++;
      $display("FAIL deserialize dut%0d got=%h required %h", k, rx, d);
    end
  endtask

  task automatic send(input int k, input logic [7:0] d);
    offer(k, d);
    watch_frame(k, d, 1'b0, 8'h00, -1, -1);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    for (int k = 0; k < 4; k++) begin
      obs = {txd[k], tx_ready[k], tx_busy[k], tx_done[k]};
      n_cmp++;
      if (obs !== 4'b1100) begin
        n_fail++;
        $display("FAIL reset_state dut%0d {txd,rdy,busy,done}=%b required 1100", k, obs);
      end
    end
  endtask

  task automatic test_basic();
    send(0, 8'h55);
    for (int r = 0; r < 3; r++) send(0, 8'($urandom_range(0, 255)));
  endtask

  task automatic test_parity();
    send(1, 8'h07);
    send(2, 8'h07);
    for (int r = 0; r < 2; r++) begin
      send(1, 8'($urandom_range(0, 255)));
      send(2, 8'($urandom_range(0, 255)));
    end
  endtask

  task automatic test_two_stop();
    send(3, 8'hFF);
    for (int r = 0; r < 2; r++) send(3, 8'($urandom_range(0, 255)));
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    offer(0, 8'hA5);
    watch_frame(0, 8'hA5, 1'b1, 8'h3C, -1, -1);
    @(negedge clk);
    watch_frame(0, 8'h3C, 1'b0, 8'h00, -1, -1);
    @(negedge clk);
    b = 8'($urandom_range(0, 255));
    offer(2, b);
    watch_frame(2, b, 1'b1, 8'hC3, -1, -1);
    @(negedge clk);
    watch_frame(2, 8'hC3, 1'b0, 8'h00, -1, -1);
    @(negedge clk);
  endtask

  task automatic test_ignore();
    logic [3:0] obs;
    offer(0, 8'h80);
    watch_frame(0, 8'h80, 1'b0, 8'h00, 30, -1);
    for (int c = 0; c < 3 * BC; c++) begin
      @(negedge clk);
      obs = {txd[0], tx_ready[0], tx_busy[0], tx_done[0]};
      n_cmp++;
      if (obs !== 4'b1100) begin
        n_fail++;
        $display("FAIL ignored_valid cycle=%0d {txd,rdy,busy,done}=%b required 1100", c, obs);
      end
    end
  endtask

  task automatic test_reset_mid();
    offer(0, 8'h0F);
    watch_frame(0, 8'h0F, 1'b0, 8'h00, -1, 45);
    @(negedge clk);
    test_reset();
    send(0, 8'h0F);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tx_valid[k] = 1'b0;
      tx_data[k]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_basic();
    test_parity();
    test_two_stop();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
